replace_plru: RTL

Parametrised tree pseudo-LRU replacement unit for set-associative caches; generalises the fixed 1/2/4-way selectors to any power-of-two way count.
- Owns per-set PLRU tree state internally, so the cache no longer stores LRU bits in SRAM.
- Answers victim queries with a registered one-cycle result.
- Accepts access updates on a separate port.
- Sits between the cache tag-compare stage and the refill/writeback controller.

---
 rtl/replace_plru_pkg.sv | 101 ++++++++++
 rtl/replace_plru_tree.sv | 32 +++
 rtl/replace_plru.sv | 117 +++++++++++
 3 files changed

// File: rtl/replace_plru_pkg.sv
// Shared types, constants and tree helpers for the PLRU replacement unit.
// Helpers work on a 16-way maximum tree; callers pass the real way count.
package cache_replace_pkg;

    localparam int MAX_WAYS  = 16;
    localparam int MAX_NODES = MAX_WAYS - 1;
    localparam int MAX_LVLS  = 4;

    // LFSR: x^8+x^6+x^5+x^4+1, shifted right, feedback into bit 7
    localparam logic [7:0] LFSR_RESET = 8'h01;
    localparam logic [7:0] LFSR_TAPS  = 8'h1D;

    function automatic int tree_nodes(input int ways);
        return ways - 1;
    endfunction

    function automatic int tree_levels(input int ways);
        int lv;
        lv = 0;
        for (int i = 1; i <= MAX_LVLS; i++) begin
            if ((1 << i) <= ways) lv = i;
        end
        return lv;
    endfunction

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {^(s & LFSR_TAPS), s[7:1]};
    endfunction

    // Walk from the root: a 0 bit points at the lower half, 1 at the upper.
    function automatic logic [MAX_WAYS-1:0] plru_victim(
        input logic [MAX_NODES-1:0] tree,
        input int                   ways
    );
        logic [MAX_WAYS-1:0] v;
        int node;
        int lv;
        lv   = tree_levels(ways);
        node = 0;
        for (int l = 0; l < MAX_LVLS; l++) begin
            if (l < lv) node = 2 * node + 1 + int'(tree[node]);
        end
        v = '0;
        v[node - tree_nodes(ways)] = 1'b1;
        return v;
    endfunction

    // Point every node on the path to the touched way away from it.
    // Zero one-hot leaves the tree alone; multiple bits use the lowest.
    function automatic logic [MAX_NODES-1:0] plru_touch(
        input logic [MAX_NODES-1:0] tree,
        input logic [MAX_WAYS-1:0]  way_onehot,
        input int                   ways
    );
        logic [MAX_NODES-1:0] t;
        logic found;
        int   idx;
        int   node;
        int   lv;
        int   b;
        t     = tree;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < MAX_WAYS; i++) begin
            if (i < ways && way_onehot[i] && !found) begin
                idx   = i;
                found = 1'b1;
            end
        end
        if (found) begin
            lv   = tree_levels(ways);
            node = 0;
            for (int l = 0; l < MAX_LVLS; l++) begin
                if (l < lv) begin
                    b       = (idx >> (lv - 1 - l)) & 1;
                    t[node] = (b == 0);
                    node    = 2 * node + 1 + b;
                end
            end
        end
        return t;
    endfunction

    function automatic logic [MAX_WAYS-1:0] first_zero_onehot(
        input logic [MAX_WAYS-1:0] vec,
        input int                  ways
    );
        logic [MAX_WAYS-1:0] v;
        logic found;
        v     = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_WAYS; i++) begin
            if (i < ways && !vec[i] && !found) begin
                v[i]  = 1'b1;
                found = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/replace_plru_tree.sv
// Combinational PLRU tree for one set: applies a touch, then walks the result.
// Ports: tree_in (WAYS-1 heap bits), touch_way (one-hot, 0 = none) -> tree_out, victim.
module plru_tree
    import cache_replace_pkg::*;
#(
    parameter int WAYS = 4
) (
    input  logic [WAYS-2:0] tree_in,
    input  logic [WAYS-1:0] touch_way,
    output logic [WAYS-2:0] tree_out,
    output logic [WAYS-1:0] victim
);

    localparam int NODES = WAYS - 1;

    logic [MAX_NODES-1:0] t_pad;
    logic [MAX_NODES-1:0] t_new;
    logic [MAX_WAYS-1:0]  w_pad;
    logic [MAX_WAYS-1:0]  v_pad;

    always_comb begin
        t_pad            = '0;
        t_pad[NODES-1:0] = tree_in;
        w_pad            = '0;
        w_pad[WAYS-1:0]  = touch_way;
        t_new            = plru_touch(t_pad, w_pad, WAYS);
        v_pad            = plru_victim(t_new, WAYS);
        tree_out         = t_new[NODES-1:0];
        victim           = v_pad[WAYS-1:0];
    end

endmodule

// File: rtl/replace_plru.sv
// Tree pseudo-LRU replacement unit: per-set state, registered victim query, touch port.
// Ports: clock, reset (sync, active-low); q_valid/q_idx/way_v/way_d -> r_valid,
// way_replace_en, need_send one cycle later; upd_en/upd_idx/upd_way touch a set.
// Build option: REPLACE_PLRU_RAND_EN picks all-valid victims from an 8-bit LFSR.
module replace_plru
    import cache_replace_pkg::*;
#(
    parameter  int WAYS  = 4,
    parameter  int SETS  = 64,
    localparam int IDX_W = $clog2(SETS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             q_valid,
    input  logic [IDX_W-1:0] q_idx,
    input  logic [WAYS-1:0]  way_v,
    input  logic [WAYS-1:0]  way_d,
    output logic             r_valid,
    output logic [WAYS-1:0]  way_replace_en,
    output logic             need_send,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic [WAYS-1:0]  upd_way
);

    localparam int NODES = WAYS - 1;

    logic [NODES-1:0] tree_q [SETS];

    logic [WAYS-1:0]  q_touch;
    logic [NODES-1:0] q_tree_nx;
    logic [WAYS-1:0]  tree_victim;

    logic [WAYS-1:0]  u_touch;
    logic [NODES-1:0] upd_tree;
    logic [WAYS-1:0]  u_victim;

    logic             upd_wr;
    logic [WAYS-1:0]  victim;
    logic [MAX_WAYS-1:0] fz_pad;
    logic [MAX_WAYS-1:0] v_pad;

    // Same-set update in this cycle is folded into the query's view.
    assign q_touch = (upd_en && upd_idx == q_idx) ? upd_way : '0;
    assign u_touch = upd_en ? upd_way : '0;
    assign upd_wr  = upd_en && (|upd_way);

    plru_tree #(.WAYS(WAYS)) u_q_tree (
        .tree_in   (tree_q[q_idx]),
        .touch_way (q_touch),
        .tree_out  (q_tree_nx),
        .victim    (tree_victim)
    );

    plru_tree #(.WAYS(WAYS)) u_u_tree (
        .tree_in   (tree_q[upd_idx]),
        .touch_way (u_touch),
        .tree_out  (upd_tree),
        .victim    (u_victim)
    );

`ifdef REPLACE_PLRU_RAND_EN
    localparam int LW = $clog2(WAYS);

    logic [7:0]      lfsr_q;
    logic [WAYS-1:0] rand_victim;

    always_comb begin
        rand_victim                   = '0;
        rand_victim[lfsr_q[LW-1:0]]   = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            lfsr_q <= LFSR_RESET;
        end else if (q_valid) begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end
`endif

    always_comb begin
        v_pad           = '1;
        v_pad[WAYS-1:0] = way_v;
        fz_pad          = first_zero_onehot(v_pad, WAYS);
        if (&way_v) begin
`ifdef REPLACE_PLRU_RAND_EN
            victim = rand_victim;
`else
            victim = tree_victim;
`endif
        end else begin
            victim = fz_pad[WAYS-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_valid        <= 1'b0;
            way_replace_en <= '0;
            need_send      <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                tree_q[s] <= '0;
            end
        end else begin
            r_valid <= q_valid;
            if (q_valid) begin
                way_replace_en <= victim;
                need_send      <= |(victim & way_v & way_d);
            end
            if (upd_wr) begin
                tree_q[upd_idx] <= upd_tree;
            end
        end
    end

endmodule
